// File: rtl/binary_tf_pkg.sv
// rtl/binary_tf_pkg.sv - shared sizes, vector types and sign helper for the binarized FFN down-projection
package binary_tf_pkg;
    localparam int D_IN    = 64;
    localparam int D_OUT   = 16;
    localparam int T_STEPS = 30;
    localparam int BANK_W  = 2;
    localparam int STEP_W  = 5;
    localparam int MISM_W  = 7;

    typedef logic [D_IN-1:0]   bvec_in_t;
    typedef logic [D_OUT-1:0]  bvec_out_t;
    typedef logic [MISM_W-1:0] mism_t;

    // Score D_IN - 2*mism is kept signed and wide enough that a tie (score 0) maps to 0.
    function automatic logic bin_sign(input mism_t mism);
        logic signed [MISM_W+1:0] score;
        score = $signed((MISM_W+2)'(D_IN)) - $signed({1'b0, mism, 1'b0});
        return !score[MISM_W+1] && (score != '0);
    endfunction
endpackage

// File: rtl/popcount64.sv
// rtl/popcount64.sv - combinational adder-tree population count of a 64-bit word
module popcount64 (
    input  logic [63:0] in,
    output logic [6:0]  out
);
    logic [1:0] l1 [32];
    logic [2:0] l2 [16];
    logic [3:0] l3 [8];
    logic [4:0] l4 [4];
    logic [5:0] l5 [2];

    genvar i;
    for (i = 0; i < 32; i++) begin : g_l1
        assign l1[i] = {1'b0, in[2*i]} + {1'b0, in[2*i+1]};
    end
    for (i = 0; i < 16; i++) begin : g_l2
        assign l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
    end
    for (i = 0; i < 8; i++) begin : g_l3
        assign l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
    end
    for (i = 0; i < 4; i++) begin : g_l4
        assign l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
    end
    for (i = 0; i < 2; i++) begin : g_l5
        assign l5[i] = {1'b0, l4[2*i]} + {1'b0, l4[2*i+1]};
    end

    assign out = {1'b0, l5[0]} + {1'b0, l5[1]};
endmodule

// File: rtl/binary_intermediate_2.sv
// rtl/binary_intermediate_2.sv - XOR-popcount sign down-projection, 64-bit in to 16-bit out per time step
module binary_intermediate_2
    import binary_tf_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BANK_W-1:0]       block_sel,
    input  logic [D_IN-1:0]         in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    w_en,
    output logic [BANK_W-1:0]       w_addr,
    input  logic [D_OUT*D_IN-1:0]   w_data,
    output logic [D_OUT-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [STEP_W-1:0]       out_step,
    output logic                    done
);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(T_STEPS - 1);

    logic              s1_valid;
    bvec_in_t          s1_data;
    logic [STEP_W-1:0] step_cnt;
    logic              adv;
    logic              accept;
    bvec_out_t         result;
    mism_t             mism [D_OUT];

    assign adv      = !out_valid || out_ready;
    assign in_ready = rst_n && !start && (!s1_valid || adv);
    assign accept   = in_valid && in_ready;

    // The ROM is read only on accept, so its held output always belongs to the beat in S1.
    assign w_en     = accept;
    assign w_addr   = accept ? block_sel : '0;
    assign out_step = step_cnt;

    genvar k;
    for (k = 0; k < D_OUT; k++) begin : g_row
        popcount64 u_popcount (
            .in  (s1_data ^ w_data[k*D_IN +: D_IN]),
            .out (mism[k])
        );
        assign result[k] = bin_sign(mism[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            step_cnt  <= '0;
            done      <= 1'b0;
        end else if (start) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            step_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
            end else if (adv) begin
                s1_valid <= 1'b0;
            end

            if (adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= result;
                end
            end

            // The handshake carrying the last step sets done; later beats keep the saturated tag.
            if (out_valid && out_ready) begin
                if (step_cnt == STEP_LAST) begin
                    done <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_binary_intermediate_2.sv
// tb/tb_binary_intermediate_2.sv - randomized self-checking bench with queue-based reference model
module tb_binary_intermediate_2;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    block_sel = '0;
    logic [63:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          w_en;
    logic [1:0]    w_addr;
    logic [1023:0] w_data = '0;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [4:0]    out_step;
    logic          done;

    binary_intermediate_2 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .block_sel(block_sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_step(out_step), .done(done)
    );

    always #5 clk = ~clk;

    logic [63:0] bank [4][16];

    always @(posedge clk) begin
        if (w_en) begin
            for (int k = 0; k < 16; k++) w_data[k*64 +: 64] <= bank[w_addr][k];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] golden(input logic [63:0] d, input logic [1:0] b);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[k] = ($countones(d ^ bank[b][k]) < 32);
        return r;
    endfunction

    typedef struct {
        logic [15:0] exp;
        int          t;
    } beat_t;

    beat_t       q[$];
    int          cyc = 0;
    int          delivered = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [4:0]  prev_step = '0;

    // Reference: each accepted beat appears two cycles later, in order, tagged with the delivery count.
    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_w_en", w_en, 0);
            chk("rst_done", done, 0);
            chk("rst_out_step", out_step, 0);
            q.delete();
            delivered = 0;
            prev_stall = 1'b0;
        end else begin
            chk("out_valid", out_valid, (q.size() > 0) && (cyc - q[0].t >= 2));
            chk("done", done, delivered >= 30);
            chk("in_ready", in_ready, !start && (q.size() < 2 || out_ready));
            chk("w_en", w_en, in_valid && in_ready);
            if (w_en) chk("w_addr", w_addr, block_sel);
            if (out_valid) begin
                chk("out_step", out_step, (delivered > 29) ? 29 : delivered);
                if (prev_stall) begin
                    chk("hold_data", out_data, prev_data);
                    chk("hold_step", out_step, prev_step);
                end
            end
            prev_stall = out_valid && !out_ready && !start;
            prev_data  = out_data;
            prev_step  = out_step;
            if (start) begin
                q.delete();
                delivered = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() > 0) begin
                        b = q.pop_front();
                        chk("out_data", out_data, b.exp);
                    end else begin
                        chk("unexpected_output", 1, 0);
                    end
                    delivered++;
                end
                if (in_valid && in_ready) begin
                    b.exp = golden(in_data, block_sel);
                    b.t   = cyc;
                    q.push_back(b);
                end
            end
        end
    end

    int   stall_cnt = 0;
    logic rand_ready = 1'b0;

    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic send(input logic [63:0] d, input logic [1:0] b, output int tries);
        logic acc;
        in_valid  = 1'b1;
        in_data   = d;
        block_sel = b;
        tries     = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            tries++;
            @(posedge clk);
            #1;
        end while (!acc && tries < 200);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int tries;
        int slow;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 16; k++) bank[b][k] = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_step", out_step, 0);
        chk("post_rst_done", done, 0);
        @(posedge clk);
        #1;

        // Zero input against all-zero rows: every bit set, two cycles after accept.
        send(64'h0, 2'd0, tries);
        @(negedge clk);
        chk("lat1_not_yet", out_valid, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 16'hFFFF);
        chk("t1_step", out_step, 0);
        drain();

        // Tie at 32 mismatches clears, 31 sets, 33 and 64 clear.
        bank[1][0] = 64'hFFFF_FFFF_0000_0000;
        bank[1][1] = 64'h0000_0000_7FFF_FFFF;
        bank[1][2] = 64'hFFFF_FFFF_FFFF_FFFF;
        bank[1][3] = 64'h0000_0001_FFFF_FFFF;
        send(64'h0, 2'd1, tries);
        @(negedge clk);
        @(negedge clk);
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 16'hFFF2);
        drain();

        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 16; k++) bank[b][k] = rnd64();

        pulse_start();
        slow = 0;
        for (int i = 0; i < 30; i++) begin
            send(rnd64(), 2'($urandom_range(0, 3)), tries);
            if (tries != 1) slow++;
        end
        chk("t3_in_ready_stalls", slow, 0);
        drain();
        @(negedge clk);
        chk("t3_done", done, 1);
        chk("t3_step_sat", out_step, 29);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            send(rnd64(), 2'($urandom_range(0, 3)), tries);
            if (i == 3) stall_cnt = 5;
        end
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) send(rnd64(), 2'(i % 4), tries);
        drain();
        rand_ready = 1'b0;

        // Two beats in flight are dropped by start, then by a reset pulse.
        stall_cnt = 30;
        send(rnd64(), 2'd2, tries);
        send(rnd64(), 2'd3, tries);
        pulse_start();
        stall_cnt = 0;
        @(negedge clk);
        chk("t6_start_valid", out_valid, 0);
        chk("t6_start_done", done, 0);
        @(posedge clk);
        #1;
        send(rnd64(), 2'd1, tries);
        @(negedge clk);
        @(negedge clk);
        chk("t6_start_next_valid", out_valid, 1);
        chk("t6_start_next_step", out_step, 0);
        drain();

        stall_cnt = 30;
        send(rnd64(), 2'd0, tries);
        send(rnd64(), 2'd1, tries);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall_cnt = 0;
        @(negedge clk);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(rnd64(), 2'd3, tries);
        @(negedge clk);
        @(negedge clk);
        chk("t6_rst_next_valid", out_valid, 1);
        chk("t6_rst_next_step", out_step, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
